// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and default pointer/count types for the FIFO
package fifo_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW = clog2(FIFO_DEPTH);
  typedef logic [FIFO_AW-1:0] fifo_ptr_t;
  typedef logic [FIFO_AW:0] fifo_count_t;
endpackage

// File: rtl/mem_fifo_sync_if.sv
// mem_fifo_sync_if: producer/consumer handshake, data and status bundle
interface mem_fifo_sync_if #(parameter int WIDTH = 8, parameter int DEPTH = 16);
  localparam int AW = fifo_pkg::clog2(DEPTH);
  logic CLR;
  logic WR_EN;
  logic [WIDTH-1:0] DATA_IN;
  logic RD_EN;
  logic [WIDTH-1:0] DATA_OUT;
  logic FULL;
  logic EMPTY;
  logic ALMOST_FULL;
  logic ALMOST_EMPTY;
  logic [AW:0] COUNT;
  logic OVERFLOW;
  logic UNDERFLOW;
  modport master (output CLR, WR_EN, DATA_IN, RD_EN,
                  input DATA_OUT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW);
  modport slave (input CLR, WR_EN, DATA_IN, RD_EN,
                 output DATA_OUT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW);
endinterface

// File: rtl/mem_array.sv
// mem_array: register-file memory, synchronous write, asynchronous read
module mem_array
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      CLK,
  input  logic                      WE,
  input  logic [clog2(DEPTH)-1:0]   WADDR,
  input  logic [WIDTH-1:0]          WDATA,
  input  logic [clog2(DEPTH)-1:0]   RADDR,
  output logic [WIDTH-1:0]          RDATA
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge CLK) if (WE) mem[WADDR] <= WDATA;
  assign RDATA = mem[RADDR];
endmodule

// File: rtl/mem_fifo_sync.sv
// mem_fifo_sync: first-word-fall-through synchronous FIFO with occupancy, almost and sticky error flags
module mem_fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic CLK,
  input logic RST,
  mem_fifo_sync_if.slave f
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic rd_ok, wr_ok, empty, full, we;
  logic [WIDTH-1:0] rdata;
  assign empty = count_q == '0;
  assign full = count_q == FULL_CNT;
  always_comb begin
    rd_ok = f.RD_EN & ~empty;
    wr_ok = f.WR_EN & (~full | rd_ok);
    we = wr_ok & ~f.CLR & ~RST;
    wr_ptr_d = f.CLR ? '0 : wr_ptr_q + {{(AW-1){1'b0}}, wr_ok};
    rd_ptr_d = f.CLR ? '0 : rd_ptr_q + {{(AW-1){1'b0}}, rd_ok};
    count_d = f.CLR ? '0 : count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    ovf_d = f.CLR ? 1'b0 : ovf_q | (f.WR_EN & ~wr_ok);
    udf_d = f.CLR ? 1'b0 : udf_q | (f.RD_EN & ~rd_ok);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  mem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .CLK(CLK), .WE(we), .WADDR(wr_ptr_q), .WDATA(f.DATA_IN), .RADDR(rd_ptr_q), .RDATA(rdata)
  );
  assign f.DATA_OUT = empty ? '0 : rdata;
  assign f.FULL = full;
  assign f.EMPTY = empty;
  assign f.ALMOST_FULL = count_q >= AF_CNT;
  assign f.ALMOST_EMPTY = count_q <= AE_CNT;
  assign f.COUNT = count_q;
  assign f.OVERFLOW = ovf_q;
  assign f.UNDERFLOW = udf_q;
endmodule

// File: tb/tb_mem_fifo_sync.sv
// tb_mem_fifo_sync: vector table, corner sequences and random traffic against a queue model
module tb_mem_fifo_sync;
  import fifo_pkg::*;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF = DEPTH - 2;
  localparam int AE = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] q[$];
  bit m_ovf, m_udf;
  mem_fifo_sync_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) f();
  mem_fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .CLK(clk), .RST(rst), .f(f)
  );
  always #5 clk = ~clk;

  typedef struct {
    bit wr; bit rd; bit clr; logic [7:0] din;
    int cnt; logic [7:0] dout; bit ovf; bit udf;
  } vec_t;
  vec_t tv[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count", 32'(f.COUNT), n);
    chk("empty", 32'(f.EMPTY), 32'(n == 0));
    chk("full", 32'(f.FULL), 32'(n == DEPTH));
    chk("almost_full", 32'(f.ALMOST_FULL), 32'(n >= AF));
    chk("almost_empty", 32'(f.ALMOST_EMPTY), 32'(n <= AE));
    chk("data_out", 32'(f.DATA_OUT), n > 0 ? 32'(q[0]) : 32'h0);
    chk("overflow", 32'(f.OVERFLOW), 32'(m_ovf));
    chk("underflow", 32'(f.UNDERFLOW), 32'(m_udf));
  endtask

  task automatic step(bit r, bit c, bit w, bit rd, logic [7:0] din);
    bit rd_ok, wr_ok;
    rst = r; f.CLR = c; f.WR_EN = w; f.RD_EN = rd; f.DATA_IN = din;
    @(posedge clk);
    if (r || c) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      rd_ok = rd && q.size() > 0;
      wr_ok = w && (q.size() < DEPTH || rd_ok);
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(din);
      if (w && !wr_ok) m_ovf = 1;
      if (rd && !rd_ok) m_udf = 1;
    end
    #1;
    rst = 0; f.CLR = 0; f.WR_EN = 0; f.RD_EN = 0;
    check_model();
  endtask

  initial begin
    tv[0] = '{1, 0, 0, 8'h11, 1, 8'h11, 0, 0};
    tv[1] = '{1, 0, 0, 8'h22, 2, 8'h11, 0, 0};
    tv[2] = '{0, 1, 0, 8'h00, 1, 8'h22, 0, 0};
    tv[3] = '{1, 1, 0, 8'h33, 1, 8'h33, 0, 0};
    tv[4] = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    tv[5] = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 1};
    tv[6] = '{1, 1, 0, 8'h44, 1, 8'h44, 0, 1};
    tv[7] = '{1, 0, 1, 8'h55, 0, 8'h00, 0, 0};
    f.CLR = 0; f.WR_EN = 0; f.RD_EN = 0; f.DATA_IN = '0;

    step(1, 0, 0, 0, 8'h0);
    chk("rst_empty", 32'(f.EMPTY), 1);
    chk("rst_ae", 32'(f.ALMOST_EMPTY), 1);
    chk("rst_count", 32'(f.COUNT), 0);
    chk("rst_dout", 32'(f.DATA_OUT), 0);
    chk("rst_full", 32'(f.FULL), 0);
    chk("rst_ovf", 32'(f.OVERFLOW), 0);

    for (int i = 0; i < 8; i++) begin
      step(0, tv[i].clr, tv[i].wr, tv[i].rd, tv[i].din);
      chk($sformatf("tv%0d_count", i), 32'(f.COUNT), tv[i].cnt);
      chk($sformatf("tv%0d_dout", i), 32'(f.DATA_OUT), 32'(tv[i].dout));
      chk($sformatf("tv%0d_ovf", i), 32'(f.OVERFLOW), 32'(tv[i].ovf));
      chk($sformatf("tv%0d_udf", i), 32'(f.UNDERFLOW), 32'(tv[i].udf));
    end

    step(1, 0, 0, 0, 8'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0, 8'(i));
      chk("fill_af", 32'(f.ALMOST_FULL), 32'(i + 1 >= 14));
    end
    chk("fill_full", 32'(f.FULL), 1);
    chk("fill_count", 32'(f.COUNT), 16);
    step(0, 0, 1, 0, 8'hAA);
    chk("ovf_count", 32'(f.COUNT), 16);
    chk("ovf_set", 32'(f.OVERFLOW), 1);
    step(0, 0, 0, 0, 8'h0);
    chk("ovf_sticky", 32'(f.OVERFLOW), 1);
    step(0, 0, 1, 1, 8'h55);
    chk("sim_full_count", 32'(f.COUNT), 16);
    chk("sim_full_head", 32'(f.DATA_OUT), 8'h01);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", 32'(f.DATA_OUT), i < 15 ? 32'(i + 1) : 32'h55);
      step(0, 0, 0, 1, 8'h0);
    end
    chk("drain_empty", 32'(f.EMPTY), 1);
    step(0, 0, 1, 1, 8'h33);
    chk("sim_empty_count", 32'(f.COUNT), 1);
    chk("sim_empty_udf", 32'(f.UNDERFLOW), 1);
    chk("sim_empty_dout", 32'(f.DATA_OUT), 8'h33);

    step(0, 1, 0, 0, 8'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 2) step(0, 0, 1, 1, 8'($urandom));
      else step(0, 0, i % 3 == 0, i % 3 == 1, 8'($urandom));
    end
    chk("wrap_ovf", 32'(f.OVERFLOW), 0);
    chk("wrap_udf", 32'(f.UNDERFLOW), 0);

    while (q.size() < DEPTH) step(0, 0, 1, 0, 8'($urandom));
    step(0, 0, 1, 0, 8'hEE);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 8'h0);
    chk("clr_pre_count", 32'(f.COUNT), 7);
    chk("clr_pre_ovf", 32'(f.OVERFLOW), 1);
    step(0, 1, 1, 0, 8'h77);
    chk("clr_count", 32'(f.COUNT), 0);
    chk("clr_empty", 32'(f.EMPTY), 1);
    chk("clr_ovf", 32'(f.OVERFLOW), 0);
    step(0, 0, 0, 0, 8'h0);
    chk("clr_discard", 32'(f.COUNT), 0);

    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 200) % 3;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < (bias == 0 ? 8 : bias == 1 ? 2 : 5),
           $urandom_range(0, 9) < (bias == 0 ? 2 : bias == 1 ? 8 : 5),
           8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
